// File: rtl/baud_frac_generator_pkg.sv
// baud_pkg: shared constants for the fractional baud generator.
//   - selector encoding (presets 0..3, custom for 4..7)
//   - preset baud list and default oversample / fraction widths
//   - calc_div(): rounded fixed-point divisor {int,frac} for a given baud
package baud_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_FRAC_W     = 4;

    localparam logic [2:0] SEL_9600   = 3'd0;
    localparam logic [2:0] SEL_19200  = 3'd1;
    localparam logic [2:0] SEL_57600  = 3'd2;
    localparam logic [2:0] SEL_115200 = 3'd3;
    localparam logic [2:0] SEL_CUSTOM = 3'd4;   // 4..7 all select the shadow register

    localparam int NUM_PRESETS = 4;
    localparam int PRESET_BAUD [NUM_PRESETS] = '{9600, 19200, 57600, 115200};

    // round(clk_freq * 2^frac_w / (baud * os)), returned as {int,frac}
    function automatic longint calc_div(input int clk_freq, input int baud,
                                        input int os, input int frac_w);
        longint num;
        longint den;
        num = longint'(clk_freq) * (longint'(1) << frac_w);
        den = longint'(baud) * longint'(os);
        return (2 * num + den) / (2 * den);
    endfunction

endpackage

// File: rtl/baud_frac_generator_frac_period_counter.sv
// frac_period_counter: one oversample period at a time, with a fractional
// accumulator that stretches a period by one cycle whenever it carries.
//   clk, reset          clock, async active-high reset
//   run                 count this cycle
//   load                restart: cnt=0, acc=0, adopt load_int/load_frac
//   load_int/load_frac  divisor to adopt on load (already clamped)
//   wrap                last cycle of the current period while running
module frac_period_counter #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [INT_W-1:0]  load_int,
    input  logic [FRAC_W-1:0] load_frac,
    output logic              wrap
);

    // period is one bit wider than int so int=max plus carry cannot overflow
    logic [INT_W:0]    cnt;
    logic [INT_W:0]    period;
    logic [FRAC_W-1:0] acc;
    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [FRAC_W:0]   sum;

    assign sum  = {1'b0, acc} + {1'b0, div_frac};
    assign wrap = run && (cnt == period - (INT_W+1)'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            period   <= (INT_W+1)'(2);
            acc      <= '0;
            div_int  <= INT_W'(2);
            div_frac <= '0;
        end else if (load) begin
            // first period after a load is the bare integer part
            cnt      <= '0;
            acc      <= '0;
            period   <= {1'b0, load_int};
            div_int  <= load_int;
            div_frac <= load_frac;
        end else if (wrap) begin
            cnt    <= '0;
            acc    <= sum[FRAC_W-1:0];
            period <= {1'b0, div_int} + {{INT_W{1'b0}}, sum[FRAC_W]};
        end else if (run) begin
            cnt <= cnt + (INT_W+1)'(1);
        end
    end

endmodule

// File: rtl/baud_frac_generator.sv
// baud_frac_generator: fractional-N oversample tick generator for the UART.
//   clk, reset              clock, async active-high reset
//   enable                  counting enable (hold when low)
//   sync_restart            re-phase pulse from the RX start-bit detector
//   baud_selector           0..3 presets, 4..7 custom shadow divisor
//   custom_div_int/_frac    custom divisor, captured by custom_load
//   tick_os/tick_mid/tick_bit  oversample, mid-bit and end-of-bit pulses
//   os_index                oversample position within the bit
//   update_pending          a new divisor is waiting for the next boundary
//   cfg_error               the active divisor was clamped to 2
module baud_frac_generator
    import baud_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int INT_W      = 16,
    parameter int FRAC_W     = DEF_FRAC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sync_restart,
    input  logic [2:0]                    baud_selector,
    input  logic [INT_W-1:0]              custom_div_int,
    input  logic [FRAC_W-1:0]             custom_div_frac,
    input  logic                          custom_load,
    output logic                          tick_os,
    output logic                          tick_mid,
    output logic                          tick_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_index,
    output logic                          update_pending,
    output logic                          cfg_error
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int DIV_W = INT_W + FRAC_W;

    localparam logic [DIV_W-1:0] PDIV [NUM_PRESETS] = '{
        DIV_W'(calc_div(CLK_FREQ, PRESET_BAUD[0], OVERSAMPLE, FRAC_W)),
        DIV_W'(calc_div(CLK_FREQ, PRESET_BAUD[1], OVERSAMPLE, FRAC_W)),
        DIV_W'(calc_div(CLK_FREQ, PRESET_BAUD[2], OVERSAMPLE, FRAC_W)),
        DIV_W'(calc_div(CLK_FREQ, PRESET_BAUD[3], OVERSAMPLE, FRAC_W))
    };

    logic              start_pending;   // restart owed on the first enabled clock after reset
    logic [2:0]        sel_q;
    logic [INT_W-1:0]  shadow_int, shadow_int_nx, cand_int, load_int;
    logic [FRAC_W-1:0] shadow_frac, shadow_frac_nx, cand_frac, load_frac;
    logic              clamp, sel_change, restart, run, wrap, apply;

    // Candidate divisor always reflects the latest selection, so whatever is
    // applied at the boundary is the most recent request.
    always_comb begin
        shadow_int_nx  = custom_load ? custom_div_int  : shadow_int;
        shadow_frac_nx = custom_load ? custom_div_frac : shadow_frac;
        if (baud_selector < SEL_CUSTOM) begin
            cand_int  = PDIV[baud_selector[1:0]][DIV_W-1:FRAC_W];
            cand_frac = PDIV[baud_selector[1:0]][FRAC_W-1:0];
        end else begin
            cand_int  = shadow_int_nx;
            cand_frac = shadow_frac_nx;
        end
    end

    assign clamp     = cand_int < INT_W'(2);
    assign load_int  = clamp ? INT_W'(2) : cand_int;
    assign load_frac = clamp ? '0 : cand_frac;

    assign sel_change = (baud_selector != sel_q) ||
                        (custom_load && baud_selector >= SEL_CUSTOM);
    assign restart    = sync_restart || (start_pending && enable);
    assign run        = enable && !start_pending;
    // boundary apply only when something is pending, so cnt never truncates
    assign apply      = restart || (wrap && update_pending);

    frac_period_counter #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_period (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .load      (apply),
        .load_int  (load_int),
        .load_frac (load_frac),
        .wrap      (wrap)
    );

    assign tick_os  = wrap && !sync_restart;
    assign tick_mid = tick_os && (os_index == OS_W'(OVERSAMPLE/2 - 1));
    assign tick_bit = tick_os && (os_index == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pending  <= 1'b1;
            sel_q          <= SEL_9600;
            shadow_int     <= PDIV[0][DIV_W-1:FRAC_W];
            shadow_frac    <= PDIV[0][FRAC_W-1:0];
            update_pending <= 1'b1;
            cfg_error      <= 1'b0;
            os_index       <= '0;
        end else begin
            sel_q       <= baud_selector;
            shadow_int  <= shadow_int_nx;
            shadow_frac <= shadow_frac_nx;
            if (apply) begin
                start_pending <= 1'b0;
                cfg_error     <= clamp;
            end
            update_pending <= apply ? 1'b0 : (update_pending | sel_change);
            if (restart)
                os_index <= '0;
            else if (tick_os)
                os_index <= os_index + OS_W'(1);
        end
    end

endmodule

// File: tb/tb_baud_frac_generator.sv
module tb_baud_frac_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sync_restart = 1'b0;
    logic [2:0]  baud_selector = 3'd3;
    logic [15:0] custom_div_int = '0;
    logic [3:0]  custom_div_frac = '0;
    logic        custom_load = 1'b0;
    logic        tick_os, tick_mid, tick_bit, update_pending, cfg_error;
    logic [3:0]  os_index;

    baud_frac_generator #(
        .CLK_FREQ(100_000_000), .OVERSAMPLE(16), .INT_W(16), .FRAC_W(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_restart(sync_restart),
        .baud_selector(baud_selector), .custom_div_int(custom_div_int),
        .custom_div_frac(custom_div_frac), .custom_load(custom_load),
        .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
        .os_index(os_index), .update_pending(update_pending), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int cyc; bit mid; bit bt; } exp_t;
    exp_t expq[$];

    // divisor table worked out by hand: round(1e8/baud) in 1/16 units
    int P_INT  [4] = '{651, 325, 108, 54};
    int P_FRAC [4] = '{1, 8, 8, 4};

    // reference model: counts down enabled cycles to the next tick; period
    // lengths come from the closed form int + floor(k*f/16) - floor((k-1)*f/16)
    bit m_init, m_pend, m_err;
    int m_int, m_frac, m_remain, m_k, m_os, m_sh_int, m_sh_frac;
    logic [2:0] m_sel_prev;

    int last_bit = -1;
    int bit_gap  = -1;

    int cur_ci = 0;
    int cur_cf = 0;
    logic [2:0] cur_sel = 3'd3;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_init = 1; m_pend = 1; m_err = 0; m_os = 0; m_sel_prev = 3'd0;
        m_sh_int = 651; m_sh_frac = 1; m_remain = 0; m_k = 0;
        m_int = 2; m_frac = 0;
    endtask

    task automatic model_apply(input int i, input int f);
        if (i < 2) begin m_int = 2; m_frac = 0; m_err = 1; end
        else begin m_int = i; m_frac = f; m_err = 0; end
        m_k = 0;
        m_remain = m_int;
    endtask

    task automatic model_step(input bit en, input bit sr, input logic [2:0] sel,
                              input bit ld, input int ci, input int cf);
        int ni, nf;
        bit change, applied;
        exp_t e;
        if (ld) begin m_sh_int = ci; m_sh_frac = cf; end
        if (sel < 3'd4) begin ni = P_INT[sel[1:0]]; nf = P_FRAC[sel[1:0]]; end
        else begin ni = m_sh_int; nf = m_sh_frac; end
        change = (sel != m_sel_prev) || (ld && sel >= 3'd4);
        m_sel_prev = sel;
        applied = 0;
        if (sr || (m_init && en)) begin
            model_apply(ni, nf);
            m_init = 0; m_os = 0; applied = 1;
        end else if (en && !m_init) begin
            m_remain--;
            if (m_remain == 0) begin
                e.cyc = cyc; e.mid = (m_os == 7); e.bt = (m_os == 15);
                expq.push_back(e);
                m_os = (m_os + 1) % 16;
                if (m_pend) begin
                    model_apply(ni, nf);
                    applied = 1;
                end else begin
                    m_k++;
                    m_remain = m_int + (m_k * m_frac) / 16 - ((m_k - 1) * m_frac) / 16;
                end
            end
        end
        m_pend = applied ? 0 : (m_pend | change);
    endtask

    task automatic do_cycle(input bit en, input bit sr, input logic [2:0] sel,
                            input bit ld, input int ci, input int cf);
        @(negedge clk);
        reset = 0; enable = en; sync_restart = sr; baud_selector = sel;
        custom_load = ld; custom_div_int = 16'(ci); custom_div_frac = 4'(cf);
        #1;
        chk("os_index", longint'(os_index), m_os);
        chk("update_pending", longint'(update_pending), m_pend);
        chk("cfg_error", longint'(cfg_error), m_err);
        model_step(en, sr, sel, ld, ci, cf);
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) do_cycle(en, 0, cur_sel, 0, cur_ci, cur_cf);
    endtask

    // reset lands in a cycle that would otherwise carry a tick
    task automatic do_reset();
        @(negedge clk);
        enable = 1; reset = 1;
        #1;
        chk("rst_tick_os", longint'(tick_os), 0);
        chk("rst_tick_mid", longint'(tick_mid), 0);
        chk("rst_tick_bit", longint'(tick_bit), 0);
        chk("rst_os_index", longint'(os_index), 0);
        chk("rst_update_pending", longint'(update_pending), 1);
        chk("rst_cfg_error", longint'(cfg_error), 0);
        model_reset();
        @(negedge clk);
    endtask

    // monitor: pops the scoreboard whenever the DUT ticks (or should have)
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (tick_os === 1'b1) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tick_unexpected: tick_os=1 at cycle %0d, none expected", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_mid", longint'(tick_mid), e.mid);
                    chk("tick_bit", longint'(tick_bit), e.bt);
                end
                if (tick_bit === 1'b1) begin
                    if (last_bit >= 0) bit_gap = cyc - last_bit;
                    last_bit = cyc;
                end
            end else begin
                chk("stray_mid_bit", longint'({tick_mid, tick_bit}), 0);
                if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                    e = expq.pop_front();
                    total++; bad++;
                    $display("FAIL tick_missing: tick_os=0 at cycle %0d, tick expected at %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int guard;
        bit en, sr, ld;
        #1 reset = 1;
        model_reset();
        #1;
        chk("reset_tick_os", longint'(tick_os), 0);
        chk("reset_os_index", longint'(os_index), 0);
        chk("reset_update_pending", longint'(update_pending), 1);
        chk("reset_cfg_error", longint'(cfg_error), 0);

        // 115200 from reset: first enabled clock restarts
        cur_sel = 3'd3;
        run(3, 0);
        last_bit = -1; bit_gap = -1;
        run(2000, 1);
        chk("bit_gap_115200", bit_gap, 868);

        // custom load with a preset selected: shadow only, nothing pending
        do_cycle(1, 0, 3'd3, 1, 20, 3);
        run(200, 1);

        // 9600 via re-phase: 16 periods sum to 10417
        cur_sel = 3'd0;
        do_cycle(1, 1, cur_sel, 0, cur_ci, cur_cf);
        last_bit = -1; bit_gap = -1;
        run(21000, 1);
        chk("bit_gap_9600", bit_gap, 10417);

        // switch 0->3 at cnt=300 of a 651/652 period
        guard = 0;
        while (m_remain != 351 && guard < 2000) begin run(1, 1); guard++; end
        chk("wait_cnt300", guard < 2000, 1);
        cur_sel = 3'd3;
        run(800, 1);

        // clamped custom divisor, then a legal one
        cur_sel = 3'd4; cur_ci = 1; cur_cf = 5;
        do_cycle(1, 0, cur_sel, 1, cur_ci, cur_cf);
        run(100, 1);
        chk("clamp_cfg_error", longint'(cfg_error), 1);
        cur_ci = 10; cur_cf = 3;
        do_cycle(1, 0, cur_sel, 1, cur_ci, cur_cf);
        run(300, 1);
        chk("unclamp_cfg_error", longint'(cfg_error), 0);

        // re-phase at cnt=30, os_index=9
        cur_sel = 3'd3;
        run(200, 1);
        guard = 0;
        while (!(m_os == 9 && m_remain == m_int - 30) && guard < 3000) begin run(1, 1); guard++; end
        chk("wait_os9", guard < 3000, 1);
        do_cycle(1, 1, cur_sel, 0, cur_ci, cur_cf);
        run(300, 1);

        // enable gap mid-period
        run(20, 1);
        run(100, 0);
        run(300, 1);

        // random traffic
        repeat (4000) begin
            en = ($urandom_range(0, 9) != 0);
            sr = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 299) == 0) cur_sel = 3'($urandom_range(0, 7));
            if (ld) begin cur_ci = $urandom_range(0, 30); cur_cf = $urandom_range(0, 15); end
            do_cycle(en, sr, cur_sel, ld, cur_ci, cur_cf);
        end

        // reset on what would be a tick cycle, then restart
        cur_sel = 3'd3;
        guard = 0;
        while (!(m_remain == 1 && !m_init) && guard < 3000) begin run(1, 1); guard++; end
        chk("wait_pre_tick", guard < 3000, 1);
        do_reset();
        run(2, 0);
        run(300, 1);

        run(5, 0);
        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_frac_generator.md
Name: baud_frac_generator

Overview:
- Parametrised successor to the fixed-preset 16x baud tick generator.
- Fractional-N divider: integer+fractional divisor per oversample period, so high baud rates stay accurate.
- Presets plus a runtime-loadable custom divisor; divisor changes are glitch-free; oversample/mid-bit/bit ticks; synchronous re-phase input for UART RX start-bit alignment.
- Sits between the UART control registers and the TX/RX engines.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- OVERSAMPLE, 16, oversample ticks per bit; power of two, >=4.
- INT_W, 16, width of the integer divisor part.
- FRAC_W, 4, width of the fractional divisor part.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  counting enable.
- sync_restart  in  1  re-phase pulse from the RX start-bit detector.
- baud_selector  in  3  0:9600, 1:19200, 2:57600, 3:115200, 4-7: custom.
- custom_div_int  in  INT_W  custom integer divisor.
- custom_div_frac  in  FRAC_W  custom fractional divisor, in units of 1/2^FRAC_W.
- custom_load  in  1  captures the custom_div_* inputs into the shadow register.
- tick_os  out  1  1-cycle pulse at the oversample rate.
- tick_mid  out  1  1-cycle pulse on the oversample tick with os_index==OVERSAMPLE/2-1 (mid-bit sample point).
- tick_bit  out  1  1-cycle pulse on the tick with os_index==OVERSAMPLE-1.
- os_index  out  $clog2(OVERSAMPLE)  oversample position within the bit.
- update_pending  out  1  a new divisor is selected but not yet applied.
- cfg_error  out  1  the active divisor was clamped.

Behaviour:
- Presets: DIV = round(CLK_FREQ*2^FRAC_W/(baud*OVERSAMPLE)); int = DIV>>FRAC_W; frac = DIV low bits. At defaults: 9600 = 651+1/16; 115200 = 54+4/16.
- Period engine:
  - cnt counts 0..period-1; tick_os is asserted combinationally while cnt==period-1 and enable=1.
  - At each boundary (tick_os cycle): {carry,acc} <= acc + frac; next period = int + carry; cnt <= 0.
  - Long-run average period = int + frac/2^FRAC_W cycles.
- os_index increments on every tick_os and wraps at OVERSAMPLE-1. tick_bit and tick_mid are registered-aligned with tick_os, in the same cycle.
- Clamping: an effective int < 2 is replaced by 2 with frac forced to 0. cfg_error is high while the active divisor is clamped.
- Divisor updates:
  - A selector change, or custom_load while the selector is >=4, latches the candidate divisor and sets update_pending.
  - The candidate is applied at the next boundary: the new period is computed from the new int/frac, acc is cleared, and update_pending is cleared.
  - cnt and os_index are never truncated mid-period, so there are no runt ticks.
  - custom_load while the selector is <4 updates the shadow register only; no pending update is raised.
  - If a second change arrives while one is pending, the latest value wins.
- sync_restart (priority over boundary and enable):
  - That cycle: tick_os, tick_mid and tick_bit are forced to 0.
  - Next cycle: cnt=0, acc=0, os_index=0, any pending divisor is applied immediately, update_pending=0.
- enable=0: cnt, acc and os_index hold and all ticks are 0. Updates are still captured and pending; they apply at the next boundary after enable returns.
- Reset (async): cnt=0, acc=0, os_index=0, all ticks 0, update_pending=1, cfg_error=0, shadow=preset 0.
  - The first clock after reset with enable=1 applies the current selection as a restart.
  - The first tick_os occurs int cycles later.
- Reset asserted mid-period aborts immediately with no tick.
- Widths:
  - acc is FRAC_W bits; the carry is the adder MSB.
  - period is INT_W+1 bits, so int=2^INT_W-1 plus carry does not overflow.

Decomposition:
- Package baud_pkg:
  - Selector encoding constants.
  - Preset baud list.
  - constant function calc_div(clk_freq, baud, os, frac_w) returning {int,frac}.
  - Default OVERSAMPLE and FRAC_W.
- Sub-module frac_period_counter: cnt, acc and the carry/period logic, with a load-on-boundary/restart port.
- The top level owns selector/shadow/pending logic, os_index, clamping and tick decode.

Test Plan:
- Selector=3, enable=1 after reset -> tick_os spacing 54,54,54,55 repeating; exactly one tick_bit per 868 cycles; tick_mid on os_index 7.
- Selector=0 -> 16 oversample periods total 10417 cycles; one 652-cycle period per 16.
- Selector 0->3 switched mid-period (cnt=300) -> the current 651/652 period completes, update_pending is high until that boundary, and the next period is 54; no runt tick.
- Custom int=1, frac=5, selector=4 -> the divisor is applied at the boundary with period 2 fixed; cfg_error=1 until custom int=10 is loaded and applied.
- sync_restart asserted at cnt=30, os_index=9 -> no tick that cycle; the next tick_os follows exactly int cycles later with os_index reading 1 after it (0 before); enable=0 for 100 cycles mid-period -> the period is extended by exactly 100 cycles.
- Reset asserted mid-period -> all outputs 0 immediately; after release the first tick_os arrives int cycles after the first enabled clock.
